dc_databank_array: RTL and testbench
====================================

DC_DATABANK_ARRAY -- requirements
Module: dc_databank_array

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bits per word; must be a multiple of 8.
REQ-002 SHALL have parameter NBANKS, default 2, meaning independent RAM banks; power of two, 1..8.
REQ-003 SHALL have parameter SETS, default 32, meaning sets per bank; power of two.
REQ-004 SHALL have parameter WAYS, default 4, meaning ways per set; power of two.
REQ-005 SHALL have parameter ROWS, default 4, meaning words per line per bank; power of two.
REQ-006 SHALL have ports in this order:
- clk  in  1  clock, rising edge;
- reset  in  1  asynchronous, active-high reset;
- req_valid  in  1  request present;
- req_retry  out  1  request not accepted this cycle;
- req_write  in  1  1 = write, 0 = read;
- req_way  in  log2(WAYS)  target way;
- req_addr  in  29  logical address;
- req_data  in  DATA_W+DATA_W/8  {byte mask, data};
- ack_valid  out  1  read data present;
- ack_retry  in  1  consumer stall;
- ack_data  out  DATA_W  read data;
- ack_perr  out  1  parity error on ack_data.

Function
REQ-007 SHALL decode the address as follows:
- row = req_addr[log2(ROWS)+log2(NBANKS)+1 : log2(NBANKS)+2];
- bank = req_addr[log2(NBANKS)+1 : 2];
- set = next log2(SETS) bits above row.
REQ-008 SHALL compute the bank row position as set*WAYS*ROWS + way*ROWS + row, using exact-width arithmetic with no truncation.
REQ-009 SHALL accept a request in a cycle where req_valid=1 and req_retry=0, and SHALL enable only the addressed bank in that cycle.
REQ-010 SHALL, on an accepted write, update only the bytes whose mask bit is 1; a write SHALL produce no ack.
REQ-011 SHALL, on an accepted read in cycle N, present ack_valid=1 with data no earlier than cycle N+1.
REQ-012 SHALL buffer read results in a 2-entry in-order ack queue; ack_valid SHALL reflect queue non-empty.
REQ-013 SHALL pop the queue head when ack_valid=1 and ack_retry=0, and SHALL hold ack_data stable while ack_retry=1.
REQ-014 SHALL assert req_retry when queue occupancy plus in-flight reads is at least 2 and no pop occurs in the same cycle.
REQ-015 SHALL sustain one read per cycle when ack_retry is held 0.
REQ-016 SHALL, for a read in cycle N+1 of the position written in cycle N, return the newly written bytes.
REQ-017 SHALL, on simultaneous push and pop, leave occupancy unchanged and preserve order.

Reset
REQ-018 SHALL, while reset=1, clear the queue and the in-flight flag and drive ack_valid=0, ack_perr=0, ack_data=0 and req_retry=1.
REQ-019 SHALL discard a read that is in flight when reset asserts; RAM contents SHALL NOT be reset.
REQ-020 SHALL deassert req_retry on the first clk edge after reset falls.

Configuration
REQ-021 SHALL, with DC_DATABANK_PARITY_EN defined, store one even-parity bit per byte and set ack_perr=1 when any byte of the delivered word mismatches.
REQ-022 SHALL, without DC_DATABANK_PARITY_EN, store no parity bits and tie ack_perr to 0.

Structure
REQ-023 SHALL take the address-field widths, the log2 helper and the request/ack struct typedefs from the shared dc_pkg package.
REQ-024 SHALL instantiate NBANKS copies of sub-module dc_databank_ram, a single-port, byte-enabled RAM with a 1-cycle read and depth SETS*WAYS*ROWS.

Verification
REQ-025 SHALL cover write-then-read: write 0xDEADBEEF with mask 0xF to set 3, way 2, row 1, then read the same position -> ack 0xDEADBEEF one cycle after the read.
REQ-026 SHALL cover partial writes: write 0x11223344 with mask 0xF, then 0xAABBCCDD with mask 0x5 -> read returns 0x11BB33DD.
REQ-027 SHALL cover back-pressure: hold ack_retry=1 while issuing 3 reads -> third read sees req_retry=1 and ack_data stays stable; release ack_retry -> acks arrive in order.
REQ-028 SHALL cover bank isolation: write distinct values at the same set/way/row in bank 0 and bank 1 -> each read returns its own value.
REQ-029 SHALL cover reset mid-operation: assert reset one cycle after accepting a read -> ack_valid=0, the dropped read is never acked, and RAM data survives.
REQ-030 SHALL, with DC_DATABANK_PARITY_EN, force a RAM bit flip -> ack_perr=1 on that ack only.

Source files
------------

// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared address-field widths, log2 helper and request/ack typedefs
//
// Purpose: common definitions for the data-cache databank array.
//   ADDR_W      logical address width seen on req_addr
//   BYTE_OFF_W  byte-offset bits below the bank field
//   BANK_IDX_W  bank index width able to hold the largest bank count (8)
//   log2/max1   elaboration-time helpers for field widths
//   dc_req_t    decoded request header (write flag + address)
//   dc_ack_t    in-flight read tag (valid + bank that owns the read data)
package dc_pkg;

  localparam int ADDR_W     = 29;
  localparam int BYTE_OFF_W = 2;
  localparam int BANK_IDX_W = 3;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 30; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Keeps vector widths legal when a field collapses to zero bits.
  function automatic int max1(input int v);
    return (v > 0) ? v : 1;
  endfunction

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
  } dc_req_t;

  typedef struct packed {
    logic                  valid;
    logic [BANK_IDX_W-1:0] bank;
  } dc_ack_t;

endpackage

// File: rtl/dc_databank_ram.sv
// rtl/dc_databank_ram.sv - single-port byte-enabled RAM with registered 1-cycle read
//
// Purpose: one databank. A write updates only the lanes whose be bit is set;
// a read registers the addressed word, which then holds until the next read.
// Contents are never reset.
// Ports:
//   clk    in   clock, rising edge
//   en     in   bank enable for this cycle
//   we     in   1 = write, 0 = read
//   be     in   per-lane write enable
//   addr   in   word position
//   wdata  in   write word (NLANES lanes of LANE_W bits)
//   rdata  out  read word from the last enabled read
module dc_databank_ram #(
  parameter int LANE_W = 8,
  parameter int NLANES = 4,
  parameter int DEPTH  = 512,
  parameter int AW     = 9
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [NLANES-1:0]        be,
  input  logic [AW-1:0]            addr,
  input  logic [LANE_W*NLANES-1:0] wdata,
  output logic [LANE_W*NLANES-1:0] rdata
);

  logic [LANE_W*NLANES-1:0] mem [DEPTH];
  logic [LANE_W*NLANES-1:0] rdata_q;
  logic [LANE_W*NLANES-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dc_databank_array.sv
// rtl/dc_databank_array.sv - banked data-cache data array with 2-entry in-order ack queue
//
// Purpose: decodes a logical address into bank/set/row, drives one
// dc_databank_ram per bank, and returns read data through a 2-entry ack
// queue whose tail stage is the RAM output register itself, so read data is
// offered the cycle after the read is accepted.
// Optional feature: DC_DATABANK_PARITY_EN adds one even-parity bit per byte
// in the RAM and reports mismatches on ack_perr.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_retry  out  request not accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_way    in   target way
//   req_addr   in   logical address
//   req_data   in   {byte mask, write data}
//   ack_valid  out  read data present
//   ack_retry  in   consumer stall
//   ack_data   out  read data
//   ack_perr   out  parity error on ack_data
module dc_databank_array
  import dc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NBANKS = 2,
  parameter int SETS   = 32,
  parameter int WAYS   = 4,
  parameter int ROWS   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_retry,
  input  logic                          req_write,
  input  logic [max1(log2(WAYS))-1:0]   req_way,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W+DATA_W/8-1:0]    req_data,
  output logic                          ack_valid,
  input  logic                          ack_retry,
  output logic [DATA_W-1:0]             ack_data,
  output logic                          ack_perr
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BANK_W = log2(NBANKS);
  localparam int ROW_W  = log2(ROWS);
  localparam int SET_W  = log2(SETS);
  localparam int WAY_W  = log2(WAYS);
  localparam int POS_W  = max1(SET_W + WAY_W + ROW_W);
  localparam int DEPTH  = SETS * WAYS * ROWS;
`ifdef DC_DATABANK_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int WORD_W = LANE_W * NBYTES;

  dc_req_t req;
  assign req = '{write: req_write, addr: req_addr};

  // ---------------- address decode ----------------
  logic [31:0]           addr_w;
  logic [31:0]           row_idx;
  logic [31:0]           set_idx;
  logic [BANK_IDX_W-1:0] bank_idx;
  logic [POS_W-1:0]      pos;

  assign addr_w = 32'(req.addr);

  // Fields are extracted with shift-and-mask so a zero-width field (one bank,
  // one row) needs no special case. The position is summed in 32 bits and
  // always fits POS_W because it is below DEPTH.
  always_comb begin
    bank_idx = BANK_IDX_W'((addr_w >> BYTE_OFF_W) & 32'(NBANKS - 1));
    row_idx  = (addr_w >> (BANK_W + BYTE_OFF_W)) & 32'(ROWS - 1);
    set_idx  = (addr_w >> (BANK_W + ROW_W + BYTE_OFF_W)) & 32'(SETS - 1);
    pos      = POS_W'(set_idx * 32'(WAYS * ROWS) + 32'(req_way) * 32'(ROWS) + row_idx);
  end

  // ---------------- write word / bank enables ----------------
  logic [NBYTES-1:0] wr_mask;
  logic [WORD_W-1:0] wr_word;
  logic              accept;
  logic [NBANKS-1:0] bank_en;

  assign wr_mask = req_data[DATA_W +: NBYTES];
  assign accept  = req_valid && !req_retry;

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wr_word[i*LANE_W +: 8] = req_data[i*8 +: 8];
`ifdef DC_DATABANK_PARITY_EN
      wr_word[i*LANE_W + 8]  = ^req_data[i*8 +: 8];
`endif
    end
  end

  always_comb begin
    bank_en = '0;
    for (int b = 0; b < NBANKS; b++) begin
      bank_en[b] = accept && (bank_idx == BANK_IDX_W'(b));
    end
  end

  logic [WORD_W-1:0] rd_word [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : gen_bank
    dc_databank_ram #(
      .LANE_W (LANE_W),
      .NLANES (NBYTES),
      .DEPTH  (DEPTH),
      .AW     (POS_W)
    ) u_ram (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (req.write),
      .be    (wr_mask),
      .addr  (pos),
      .wdata (wr_word),
      .rdata (rd_word[b])
    );
  end

  // ---------------- ack queue ----------------
  dc_ack_t           inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] q_data_q [2];
  logic [DATA_W-1:0] q_data_d [2];
  logic [1:0]        q_perr_q, q_perr_d;
  logic              rst_done_q, rst_done_d;

  logic [WORD_W-1:0] ram_word;
  logic [DATA_W-1:0] ram_data;
  logic              ram_perr;
  logic              head_bypass;
  logic              pop;
  logic              q_pop;
  logic              q_push;
  logic              wr_idx;

  // Read data of the in-flight read, taken from the bank that served it.
  always_comb begin
    ram_word = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (inflight_q.bank == BANK_IDX_W'(b)) ram_word = rd_word[b];
    end
    ram_data = '0;
    ram_perr = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      ram_data[i*8 +: 8] = ram_word[i*LANE_W +: 8];
`ifdef DC_DATABANK_PARITY_EN
      ram_perr = ram_perr | (^ram_word[i*LANE_W +: 9]);
`endif
    end
  end

  // The in-flight read counts as the youngest queue entry. When the stored
  // queue is empty it is offered directly; if not popped it is copied into
  // the stored queue, so the presented word never changes under ack_retry.
  assign head_bypass = (occ_q == 2'd0) && inflight_q.valid;
  assign ack_valid   = (occ_q != 2'd0) || inflight_q.valid;
  assign ack_data    = head_bypass ? ram_data : q_data_q[0];
  assign ack_perr    = head_bypass ? ram_perr : q_perr_q[0];
  assign pop         = ack_valid && !ack_retry;

  // Held high until the first clock edge after reset releases.
  assign req_retry = !rst_done_q ||
                     (((3'(occ_q) + 3'(inflight_q.valid)) >= 3'd2) && !pop);

  always_comb begin
    q_pop  = pop && (occ_q != 2'd0);
    q_push = inflight_q.valid && !(pop && head_bypass);
    wr_idx = (occ_q > (q_pop ? 2'd1 : 2'd0));

    occ_d    = occ_q + (q_push ? 2'd1 : 2'd0) - (q_pop ? 2'd1 : 2'd0);
    q_data_d = q_data_q;
    q_perr_d = q_perr_q;
    if (q_pop) begin
      q_data_d[0] = q_data_q[1];
      q_perr_d[0] = q_perr_q[1];
    end
    if (q_push) begin
      q_data_d[wr_idx] = ram_data;
      q_perr_d[wr_idx] = ram_perr;
    end

    inflight_d.valid = accept && !req.write;
    inflight_d.bank  = bank_idx;
    rst_done_d       = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q  <= '0;
      occ_q       <= 2'd0;
      q_data_q[0] <= '0;
      q_data_q[1] <= '0;
      q_perr_q    <= 2'b00;
      rst_done_q  <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      q_data_q    <= q_data_d;
      q_perr_q    <= q_perr_d;
      rst_done_q  <= rst_done_d;
    end
  end

endmodule

// File: tb/tb_dc_databank_array.sv
// tb/tb_dc_databank_array.sv - directed self-checking bench for dc_databank_array
module tb_dc_databank_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_retry;
  logic        req_write;
  logic [1:0]  req_way;
  logic [28:0] req_addr;
  logic [35:0] req_data;
  logic        ack_valid;
  logic        ack_retry;
  logic [31:0] ack_data;
  logic        ack_perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dc_databank_array dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_retry (req_retry),
    .req_write (req_write),
    .req_way   (req_way),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack_valid (ack_valid),
    .ack_retry (ack_retry),
    .ack_data  (ack_data),
    .ack_perr  (ack_perr)
  );

  // Address layout for the default build: [1:0] byte, [2] bank, [4:3] row, [9:5] set.
  function automatic logic [28:0] mk_addr(input int set, input int row, input int bank);
    return 29'((set << 5) | (row << 3) | (bank << 2));
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] way, input logic [28:0] addr,
                       input logic [3:0] mask, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = w;
    req_way   = way;
    req_addr  = addr;
    req_data  = {mask, data};
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_retry = 1'b0; req_way = 2'd0; req_addr = '0; req_data = '0;
    idle();
    repeat (2) step();
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL rst_retry: got %b want 1", req_retry); end
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid: got %b want 0", ack_valid); end
    checks++; if (ack_data !== 32'h0) begin errors++; $display("FAIL rst_ack_data: got %h want 00000000", ack_data); end
    checks++; if (ack_perr !== 1'b0) begin errors++; $display("FAIL rst_ack_perr: got %b want 0", ack_perr); end
    reset = 1'b0;
    #1;
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL retry_before_edge: got %b want 1", req_retry); end
    step();
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL retry_after_edge: got %b want 0", req_retry); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 2'd2, mk_addr(3, 1, 0), 4'hF, 32'hDEADBEEF);
    step();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL write_no_ack: got %b want 0", ack_valid); end
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    checks++; if (ack_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b want 1", ack_valid); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h want deadbeef", ack_data); end
    checks++; if (ack_perr !== 1'b0) begin errors++; $display("FAIL wr_rd_perr: got %b want 0", ack_perr); end
    idle();
    step();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_drained: got %b want 0", ack_valid); end
  endtask

  task automatic test_partial_write();
    drive(1'b1, 2'd1, mk_addr(5, 2, 1), 4'hF, 32'h11223344);
    step();
    drive(1'b1, 2'd1, mk_addr(5, 2, 1), 4'h5, 32'hAABBCCDD);
    step();
    drive(1'b0, 2'd1, mk_addr(5, 2, 1), 4'h0, 32'h0);
    step();
    checks++; if (ack_data !== 32'h11BB33DD) begin errors++; $display("FAIL partial_data: got %h want 11bb33dd", ack_data); end
    idle();
    step();
  endtask

  task automatic test_back_pressure();
    ack_retry = 1'b1;
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL bp_second_open: got %b want 0", req_retry); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_head_first: got %h want deadbeef", ack_data); end
    drive(1'b0, 2'd1, mk_addr(5, 2, 1), 4'h0, 32'h0);
    step();
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL bp_third_retry: got %b want 1", req_retry); end
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL bp_still_retry: got %b want 1", req_retry); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_head_stable: got %h want deadbeef", ack_data); end
    idle();
    ack_retry = 1'b0;
    step();
    checks++; if (ack_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b want 1", ack_valid); end
    checks++; if (ack_data !== 32'h11BB33DD) begin errors++; $display("FAIL bp_second_order: got %h want 11bb33dd", ack_data); end
    step();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", ack_valid); end
  endtask

  task automatic test_bank_isolation();
    drive(1'b1, 2'd3, mk_addr(7, 3, 0), 4'hF, 32'h0BADF00D);
    step();
    drive(1'b1, 2'd3, mk_addr(7, 3, 1), 4'hF, 32'hCAFEBABE);
    step();
    drive(1'b0, 2'd3, mk_addr(7, 3, 0), 4'h0, 32'h0);
    step();
    checks++; if (ack_data !== 32'h0BADF00D) begin errors++; $display("FAIL iso_bank0: got %h want 0badf00d", ack_data); end
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL iso_streaming: got %b want 0", req_retry); end
    drive(1'b0, 2'd3, mk_addr(7, 3, 1), 4'h0, 32'h0);
    step();
    checks++; if (ack_data !== 32'hCAFEBABE) begin errors++; $display("FAIL iso_bank1: got %h want cafebabe", ack_data); end
    idle();
    step();
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL iso_drained: got %b want 0", ack_valid); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    ack_retry = 1'b1;
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", ack_valid); end
    checks++; if (ack_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 00000000", ack_data); end
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL mid_rst_retry: got %b want 1", req_retry); end
    step();
    reset = 1'b0;
    ack_retry = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      step();
      if (ack_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_dropped_read: got %b want 0", seen); end
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    checks++; if (ack_valid !== 1'b1) begin errors++; $display("FAIL mid_survive_valid: got %b want 1", ack_valid); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_survive_data: got %h want deadbeef", ack_data); end
    idle();
    step();
  endtask

`ifdef DC_DATABANK_PARITY_EN
  task automatic test_parity();
    // set 9, way 0, row 0, bank 0 -> position 9*16 = 144
    drive(1'b1, 2'd0, mk_addr(9, 0, 0), 4'hF, 32'h12345678);
    step();
    idle();
    step();
    dut.gen_bank[0].u_ram.mem[144][0] = ~dut.gen_bank[0].u_ram.mem[144][0];
    drive(1'b0, 2'd0, mk_addr(9, 0, 0), 4'h0, 32'h0);
    step();
    checks++; if (ack_perr !== 1'b1) begin errors++; $display("FAIL par_flip: got %b want 1", ack_perr); end
    drive(1'b0, 2'd2, mk_addr(3, 1, 0), 4'h0, 32'h0);
    step();
    checks++; if (ack_perr !== 1'b0) begin errors++; $display("FAIL par_clean: got %b want 0", ack_perr); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin errors++; $display("FAIL par_clean_data: got %h want deadbeef", ack_data); end
    idle();
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_pressure();
    test_bank_isolation();
    test_reset_mid();
`ifdef DC_DATABANK_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
